// File: rtl/box_pkg.sv
// Shared types and helpers for the frame-synchronous box scheduler.
// Coordinates are carried at CW bits internally and trimmed at the ports.
package box_pkg;

    localparam int CW = 16;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        CLEAR
    } sched_state_e;

    typedef struct packed {
        logic [CW-1:0] start_x;
        logic [CW-1:0] start_y;
        logic [CW-1:0] end_x;
        logic [CW-1:0] end_y;
        logic [23:0]   color;
    } box_t;

    function automatic logic [CW-1:0] sat(
        input logic [CW-1:0] v,
        input logic [CW-1:0] mx
    );
        return (v > mx) ? mx : v;
    endfunction

    function automatic box_t norm_box(
        input logic [CW-1:0] x0,
        input logic [CW-1:0] x1,
        input logic [CW-1:0] y0,
        input logic [CW-1:0] y1,
        input logic [23:0]   color,
        input logic [CW-1:0] xmax,
        input logic [CW-1:0] ymax
    );
        box_t b;
        b.start_x = sat((x0 < x1) ? x0 : x1, xmax);
        b.end_x   = sat((x0 < x1) ? x1 : x0, xmax);
        b.start_y = sat((y0 < y1) ? y0 : y1, ymax);
        b.end_y   = sat((y0 < y1) ? y1 : y0, ymax);
        b.color   = color;
        return b;
    endfunction

endpackage

// File: rtl/box_slot.sv
// One box slot: shadow copy, frame-stable active copy and expiry age.
// Active contents only move on commit or clear.
module box_slot
    import box_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic wr_en,
    input  box_t wr_box,
    input  logic commit,
    input  logic clear,
    output box_t active,
    output logic live
);

    localparam int AW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW-1:0] LAST = AW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    box_t          shadow;
    logic          dirty;
    logic [AW-1:0] age;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow <= '0;
            active <= '0;
            dirty  <= 1'b0;
            age    <= '0;
            live   <= 1'b0;
        end else if (clear) begin
            shadow <= '0;
            active <= '0;
            dirty  <= 1'b0;
            age    <= '0;
            live   <= 1'b0;
        end else if (commit) begin
            if (dirty) begin
                active <= shadow;
                age    <= '0;
                live   <= 1'b1;
                dirty  <= 1'b0;
            end else if (live && TIMEOUT != 0) begin
                // age stops growing once the slot expires, so it saturates
                age <= age + 1'b1;
                if (age == LAST) begin
                    active <= '0;
                    live   <= 1'b0;
                end
            end
        end else if (wr_en) begin
            shadow <= wr_box;
            dirty  <= 1'b1;
        end
    end

endmodule

// File: rtl/box_scheduler.sv
// Frame-synchronous box table: shadow writes, commit on vsync rise,
// expiry of stale slots and a slot-by-slot clear walk.
module box_scheduler
    import box_pkg::*;
#(
    parameter  int N_BOX   = 4,
    parameter  int H_ACT   = 1280,
    parameter  int V_ACT   = 720,
    parameter  int TIMEOUT = 8,
    localparam int XW      = $clog2(H_ACT),
    localparam int YW      = $clog2(V_ACT),
    localparam int SW      = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                vsync,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SW-1:0]       req_slot,
    input  logic [XW-1:0]       req_x0,
    input  logic [XW-1:0]       req_x1,
    input  logic [YW-1:0]       req_y0,
    input  logic [YW-1:0]       req_y1,
    input  logic [23:0]         req_color,
    output logic [N_BOX*XW-1:0] start_xs,
    output logic [N_BOX*XW-1:0] end_xs,
    output logic [N_BOX*YW-1:0] start_ys,
    output logic [N_BOX*YW-1:0] end_ys,
    output logic [N_BOX*24-1:0] colors,
    output logic [N_BOX-1:0]    live
);

    sched_state_e  state;
    sched_state_e  state_nx;
    logic          vs_d;
    logic          vs_rise;
    logic [SW-1:0] cnt;
    logic          accept;
    box_t          wr_box;
    box_t          act [N_BOX];

    assign vs_rise   = vsync && !vs_d;
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign wr_box    = norm_box(CW'(req_x0), CW'(req_x1),
                                CW'(req_y0), CW'(req_y1), req_color,
                                CW'(H_ACT - 1), CW'(V_ACT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            vs_d  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            vs_d  <= vsync;
            cnt   <= (state == CLEAR && !clr) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (vs_rise) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            CLEAR:   if (cnt == SW'(N_BOX - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // clear has priority over a frame edge and restarts the walk
        if (clr) state_nx = CLEAR;
    end

    for (genvar i = 0; i < N_BOX; i++) begin : g_slot
        logic unused_hi;

        box_slot #(
            .TIMEOUT(TIMEOUT)
        ) u_slot (
            .clk    (clk),
            .rstn   (rstn),
            .wr_en  (accept && req_slot == SW'(i)),
            .wr_box (wr_box),
            .commit (state == COMMIT),
            .clear  (state == CLEAR && cnt == SW'(i)),
            .active (act[i]),
            .live   (live[i])
        );

        assign start_xs[i*XW +: XW] = act[i].start_x[XW-1:0];
        assign end_xs[i*XW +: XW]   = act[i].end_x[XW-1:0];
        assign start_ys[i*YW +: YW] = act[i].start_y[YW-1:0];
        assign end_ys[i*YW +: YW]   = act[i].end_y[YW-1:0];
        assign colors[i*24 +: 24]   = act[i].color;
        assign unused_hi = ^{act[i].start_x[CW-1:XW], act[i].end_x[CW-1:XW],
                             act[i].start_y[CW-1:YW], act[i].end_y[CW-1:YW]};
    end

endmodule

// File: tb/tb_box_scheduler.sv
// Bench for box_scheduler: directed frame scenarios plus random traffic,
// every cycle checked against a frame-level model of the box table.
`timescale 1ns/1ps
module tb_box_scheduler;

    localparam int NB = 4;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int TO = 3;
    localparam int HM = 1279;
    localparam int VM = 719;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic vsync = 1'b0;
    logic clr = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [1:0] req_slot = '0;
    logic [XW-1:0] req_x0 = '0;
    logic [XW-1:0] req_x1 = '0;
    logic [YW-1:0] req_y0 = '0;
    logic [YW-1:0] req_y1 = '0;
    logic [23:0] req_color = '0;
    logic [NB*XW-1:0] start_xs;
    logic [NB*XW-1:0] end_xs;
    logic [NB*YW-1:0] start_ys;
    logic [NB*YW-1:0] end_ys;
    logic [NB*24-1:0] colors;
    logic [NB-1:0] live;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    box_scheduler #(
        .N_BOX(NB), .H_ACT(1280), .V_ACT(720), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .vsync(vsync), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_slot(req_slot),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .req_color(req_color), .start_xs(start_xs), .end_xs(end_xs),
        .start_ys(start_ys), .end_ys(end_ys), .colors(colors), .live(live)
    );

    task automatic check(input string nm, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // frame-level model: pending writes, displayed boxes, frames since load
    int sh_sx[NB], sh_sy[NB], sh_ex[NB], sh_ey[NB];
    logic [23:0] sh_c[NB];
    bit pend[NB];
    int m_sx[NB], m_sy[NB], m_ex[NB], m_ey[NB];
    logic [23:0] m_c[NB];
    bit m_live[NB];
    int m_frames[NB];
    bit commit_now, prev_vs, m_acc;
    int clr_left;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic drop_slot(input int k);
        sh_sx[k] = 0; sh_sy[k] = 0; sh_ex[k] = 0; sh_ey[k] = 0; sh_c[k] = 0;
        pend[k] = 0;
        m_sx[k] = 0; m_sy[k] = 0; m_ex[k] = 0; m_ey[k] = 0; m_c[k] = 0;
        m_live[k] = 0; m_frames[k] = 0;
    endtask

    always @(posedge clk or negedge rstn) begin : model
        bit rdy, rise, nxt;
        int s, a, b;
        if (!rstn) begin
            for (int i = 0; i < NB; i++) drop_slot(i);
            commit_now = 0; prev_vs = 0; m_acc = 0; clr_left = 0;
        end else begin
            rdy = (clr_left == 0) && !commit_now;
            rise = vsync && !prev_vs;
            nxt = rdy && rise && !clr;
            m_acc = rdy && req_valid;
            s = int'(req_slot);
            if (m_acc && s < NB) begin
                a = int'(req_x0); b = int'(req_x1);
                sh_sx[s] = sat((a < b) ? a : b, HM);
                sh_ex[s] = sat((a < b) ? b : a, HM);
                a = int'(req_y0); b = int'(req_y1);
                sh_sy[s] = sat((a < b) ? a : b, VM);
                sh_ey[s] = sat((a < b) ? b : a, VM);
                sh_c[s] = req_color;
                pend[s] = 1;
            end
            if (commit_now) begin
                for (int i = 0; i < NB; i++) begin
                    if (pend[i]) begin
                        m_sx[i] = sh_sx[i]; m_sy[i] = sh_sy[i];
                        m_ex[i] = sh_ex[i]; m_ey[i] = sh_ey[i];
                        m_c[i] = sh_c[i]; m_live[i] = 1;
                        m_frames[i] = 0; pend[i] = 0;
                    end else if (m_live[i]) begin
                        m_frames[i]++;
                        if (m_frames[i] >= TO) begin
                            m_sx[i] = 0; m_sy[i] = 0; m_ex[i] = 0; m_ey[i] = 0;
                            m_c[i] = 0; m_live[i] = 0;
                        end
                    end
                end
            end
            if (clr_left > 0) begin
                drop_slot(NB - clr_left);
                clr_left--;
            end
            if (clr) clr_left = NB;
            commit_now = nxt;
            prev_vs = vsync;
        end
    end

    logic [NB*XW-1:0] e_sx, e_ex;
    logic [NB*YW-1:0] e_sy, e_ey;
    logic [NB*24-1:0] e_c;
    logic [NB-1:0] e_live;

    always @(negedge clk) begin
        if (rstn && chk_on) begin
            for (int i = 0; i < NB; i++) begin
                e_sx[i*XW +: XW] = XW'(m_sx[i]);
                e_ex[i*XW +: XW] = XW'(m_ex[i]);
                e_sy[i*YW +: YW] = YW'(m_sy[i]);
                e_ey[i*YW +: YW] = YW'(m_ey[i]);
                e_c[i*24 +: 24] = m_c[i];
                e_live[i] = m_live[i];
            end
            check("ready", req_ready, (clr_left == 0) && !commit_now);
            check("live", live, e_live);
            check("start_xs", start_xs, e_sx);
            check("end_xs", end_xs, e_ex);
            check("start_ys", start_ys, e_sy);
            check("end_ys", end_ys, e_ey);
            check("colors", colors, e_c);
        end
    end

    task automatic wr(input int s, input int x0, input int x1,
                      input int y0, input int y1, input logic [23:0] c);
        int k;
        req_slot = 2'(s); req_x0 = XW'(x0); req_x1 = XW'(x1);
        req_y0 = YW'(y0); req_y1 = YW'(y1); req_color = c;
        req_valid = 1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_acc && k < 20);
        if (!m_acc) begin
            n_chk++; n_fail++;
            $display("FAIL wr_timeout: slot %0d not accepted after %0d cycles", s, k);
        end
        req_valid = 0;
    endtask

    task automatic frame();
        vsync = 1;
        @(negedge clk);
        vsync = 0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, flen;
        repeat (3) @(negedge clk);
        rstn = 1;
        chk_on = 1;
        @(negedge clk);
        check("rst_live", live, 0);
        check("rst_sx", start_xs, 0);
        check("rst_ready", req_ready, 1);

        wr(1, 100, 300, 50, 200, 24'hFF0000);
        repeat (3) @(negedge clk);
        check("pre_commit_live", live, 0);
        check("pre_commit_sx", start_xs, 0);
        frame();
        check("s1_sx", start_xs[XW +: XW], 100);
        check("s1_sy", start_ys[YW +: YW], 50);
        check("s1_ex", end_xs[XW +: XW], 300);
        check("s1_ey", end_ys[YW +: YW], 200);
        check("s1_col", colors[24 +: 24], 24'hFF0000);
        check("s1_live", live, 4'b0010);

        wr(0, 400, 2000, 700, 10, 24'h00FF00);
        frame();
        check("norm_sx", start_xs[0 +: XW], 400);
        check("norm_ex", end_xs[0 +: XW], 1279);
        check("norm_sy", start_ys[0 +: YW], 10);
        check("norm_ey", end_ys[0 +: YW], 700);
        check("norm_live", live, 4'b0011);

        wr(2, 10, 20, 30, 40, 24'h111111);
        wr(2, 6, 5, 6, 5, 24'h0000FF);
        frame();
        check("lww_sx", start_xs[2*XW +: XW], 5);
        check("lww_ex", end_xs[2*XW +: XW], 6);
        check("lww_sy", start_ys[2*YW +: YW], 5);
        check("lww_ey", end_ys[2*YW +: YW], 6);
        check("lww_col", colors[2*24 +: 24], 24'h0000FF);
        check("lww_live", live, 4'b0111);

        wr(3, 1, 2, 3, 4, 24'hABCDEF);
        frame();
        check("exp1_live", live, 4'b1101);
        check("exp1_s1_sx", start_xs[XW +: XW], 0);
        frame();
        check("exp2_live", live, 4'b1100);
        frame();
        check("exp3_live", live, 4'b1000);
        wr(3, 7, 8, 9, 10, 24'h123456);
        frame();
        check("refresh_live", live, 4'b1000);
        check("refresh_sx", start_xs[3*XW +: XW], 7);
        frame();
        check("refresh_f1", live, 4'b1000);
        frame();
        check("refresh_f2", live, 4'b1000);
        frame();
        check("refresh_f3", live, 4'b0000);

        for (int i = 0; i < NB; i++) wr(i, 20 * i, 20 * i + 9, i, i + 9, 24'(i + 1));
        frame();
        check("all_live", live, 4'b1111);
        clr = 1;
        @(negedge clk);
        clr = 0;
        check("clr_rdy0", req_ready, 0);
        vsync = 1;
        @(negedge clk);
        vsync = 0;
        check("clr_rdy1", req_ready, 0);
        @(negedge clk);
        check("clr_rdy2", req_ready, 0);
        @(negedge clk);
        check("clr_rdy3", req_ready, 0);
        @(negedge clk);
        check("clr_done_rdy", req_ready, 1);
        check("clr_live", live, 0);
        check("clr_sx", start_xs, 0);
        check("clr_col", colors, 0);
        @(negedge clk);
        check("clr_no_commit", req_ready, 1);

        vsync = 1;
        @(negedge clk);
        vsync = 0;
        check("hold_rdy_low", req_ready, 0);
        req_slot = 2'd0; req_x0 = 11'd11; req_x1 = 11'd22;
        req_y0 = 10'd33; req_y1 = 10'd44; req_color = 24'h0A0B0C;
        req_valid = 1;
        @(negedge clk);
        check("hold_rdy_back", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        frame();
        check("hold_sx", start_xs[0 +: XW], 11);
        check("hold_ey", end_ys[0 +: YW], 44);
        check("hold_live", live, 4'b0001);

        wr(2, 1, 1, 1, 1, 24'h1);
        wr(3, 2, 2, 2, 2, 24'h2);
        frame();
        clr = 1;
        @(negedge clk);
        clr = 0;
        @(negedge clk);
        #1 rstn = 0;
        #1;
        check("rst_mid_live", live, 0);
        check("rst_mid_sx", start_xs, 0);
        check("rst_mid_col", colors, 0);
        check("rst_mid_ready", req_ready, 1);
        @(negedge clk);
        rstn = 1;

        fc = 0;
        flen = 20;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!req_valid || m_acc) begin
                req_valid = ($urandom_range(0, 2) == 0);
                req_slot = 2'($urandom_range(0, 3));
                req_x0 = 11'($urandom_range(0, 2047));
                req_x1 = 11'($urandom_range(0, 2047));
                req_y0 = 10'($urandom_range(0, 1023));
                req_y1 = 10'($urandom_range(0, 1023));
                req_color = 24'($urandom);
            end
            vsync = (fc < 2);
            fc++;
            if (fc >= flen) begin
                fc = 0;
                flen = $urandom_range(6, 40);
            end
            clr = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        req_valid = 0;
        clr = 0;
        vsync = 0;
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
